// File: rtl/mem_port_arbiter.sv
// Unified memory port arbiter: shares one memory port between instruction
// fetch and data load/store. Data side has priority, instruction side is
// guaranteed a grant after STARVE_LIMIT consecutive data grants while it
// waits. Every transaction is bounded by TIMEOUT busy cycles. All outputs
// are registered.
module mem_port_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4,
  parameter int unsigned TIMEOUT      = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        inst_mem_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  input  logic [3:0]  d_be,
  output logic [31:0] d_rdata,
  output logic        data_mem_ack,
  output logic        m_req,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  output logic [3:0]  m_be,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        bus_err,
  output logic        grant_d
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TMO_LAST   = TW'(TIMEOUT - 1);
  localparam logic [3:0]    STARVE_LIM = 4'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    IDLE,
    BUSY_I,
    BUSY_D,
    RESP
  } state_e;

  state_e        state_q, state_d;
  logic          m_req_q, m_req_d;
  logic          m_we_q, m_we_d;
  logic [31:0]   m_addr_q, m_addr_d;
  logic [31:0]   m_wdata_q, m_wdata_d;
  logic [3:0]    m_be_q, m_be_d;
  logic [31:0]   i_rdata_q, i_rdata_d;
  logic [31:0]   d_rdata_q, d_rdata_d;
  logic          i_ack_q, i_ack_d;
  logic          d_ack_q, d_ack_d;
  logic          bus_err_q, bus_err_d;
  logic          grant_d_q, grant_d_d;
  logic [3:0]    starve_q, starve_d;
  logic [TW-1:0] tmo_q, tmo_d;

  // State and output registers; reset abandons any transaction in flight.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q   <= IDLE;
      m_req_q   <= 1'b0;
      m_we_q    <= 1'b0;
      m_addr_q  <= '0;
      m_wdata_q <= '0;
      m_be_q    <= '0;
      i_rdata_q <= '0;
      d_rdata_q <= '0;
      i_ack_q   <= 1'b0;
      d_ack_q   <= 1'b0;
      bus_err_q <= 1'b0;
      grant_d_q <= 1'b0;
      starve_q  <= '0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      m_req_q   <= m_req_d;
      m_we_q    <= m_we_d;
      m_addr_q  <= m_addr_d;
      m_wdata_q <= m_wdata_d;
      m_be_q    <= m_be_d;
      i_rdata_q <= i_rdata_d;
      d_rdata_q <= d_rdata_d;
      i_ack_q   <= i_ack_d;
      d_ack_q   <= d_ack_d;
      bus_err_q <= bus_err_d;
      grant_d_q <= grant_d_d;
      starve_q  <= starve_d;
      tmo_q     <= tmo_d;
    end
  end

  // Arbitration, transaction tracking and next values of every registered output.
  // Acks and bus_err are set on the edge entering RESP so they are visible
  // exactly during the single RESP cycle.
  always_comb begin
    state_d   = state_q;
    m_req_d   = m_req_q;
    m_we_d    = m_we_q;
    m_addr_d  = m_addr_q;
    m_wdata_d = m_wdata_q;
    m_be_d    = m_be_q;
    i_rdata_d = i_rdata_q;
    d_rdata_d = d_rdata_q;
    i_ack_d   = 1'b0;
    d_ack_d   = 1'b0;
    bus_err_d = 1'b0;
    grant_d_d = grant_d_q;
    starve_d  = starve_q;
    tmo_d     = tmo_q;

    unique case (state_q)
      IDLE: begin
        if (d_req && (!i_req || (starve_q < STARVE_LIM))) begin
          state_d   = BUSY_D;
          m_req_d   = 1'b1;
          m_we_d    = d_we;
          m_addr_d  = d_addr;
          m_wdata_d = d_wdata;
          m_be_d    = d_be;
          grant_d_d = 1'b1;
          tmo_d     = '0;
          // Only reachable below the limit when i_req waits, so this saturates.
          starve_d  = i_req ? (starve_q + 4'd1) : '0;
        end else if (i_req) begin
          state_d   = BUSY_I;
          m_req_d   = 1'b1;
          m_we_d    = 1'b0;
          m_addr_d  = i_addr;
          m_be_d    = 4'hF;
          grant_d_d = 1'b0;
          tmo_d     = '0;
          starve_d  = '0;
        end
      end

      BUSY_I, BUSY_D: begin
        if (m_ack) begin
          if (state_q == BUSY_D) begin
            d_rdata_d = m_rdata;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = m_rdata;
            i_ack_d   = 1'b1;
          end
          m_req_d   = 1'b0;
          grant_d_d = 1'b0;
          state_d   = RESP;
        end else if (tmo_q == TMO_LAST) begin
          if (state_q == BUSY_D) begin
            d_rdata_d = '0;
            d_ack_d   = 1'b1;
          end else begin
            i_rdata_d = '0;
            i_ack_d   = 1'b1;
          end
          bus_err_d = 1'b1;
          m_req_d   = 1'b0;
          grant_d_d = 1'b0;
          state_d   = RESP;
        end else begin
          tmo_d = tmo_q + TW'(1);
        end
      end

      RESP: begin
        grant_d_d = 1'b0;
        tmo_d     = '0;
        state_d   = IDLE;
      end

      default: state_d = IDLE;
    endcase
  end

  assign m_req        = m_req_q;
  assign m_we         = m_we_q;
  assign m_addr       = m_addr_q;
  assign m_wdata      = m_wdata_q;
  assign m_be         = m_be_q;
  assign i_rdata      = i_rdata_q;
  assign d_rdata      = d_rdata_q;
  assign inst_mem_ack = i_ack_q;
  assign data_mem_ack = d_ack_q;
  assign bus_err      = bus_err_q;
  assign grant_d      = grant_d_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: transaction-level reference
// model compared every cycle, plus directed scenarios with literal expectations.
module tb_mem_port_arbiter;

  localparam int unsigned SL = 4;
  localparam int unsigned TO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req, d_req, d_we;
  logic [31:0] i_addr, d_addr, d_wdata;
  logic [3:0]  d_be;
  logic [31:0] i_rdata, d_rdata;
  logic        inst_mem_ack, data_mem_ack;
  logic        m_req, m_we;
  logic [31:0] m_addr, m_wdata;
  logic [3:0]  m_be;
  logic [31:0] m_rdata = '0;
  logic        m_ack   = 1'b0;
  logic        bus_err, grant_d;

  mem_port_arbiter #(.STARVE_LIMIT(SL), .TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_rdata(i_rdata), .inst_mem_ack(inst_mem_ack),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata), .d_be(d_be),
    .d_rdata(d_rdata), .data_mem_ack(data_mem_ack),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_be(m_be),
    .m_rdata(m_rdata), .m_ack(m_ack), .bus_err(bus_err), .grant_d(grant_d)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit chk_en = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: one owner at a time, busy for up to TO cycles, then a
  // single response cycle before the port can be granted again.
  int          ph;        // 0 idle, 1 busy, 2 response cycle
  int          busy_cyc;
  int          dstreak;
  bit          own_d;
  logic        exp_m_req, exp_m_we, exp_iack, exp_dack, exp_err, exp_grant;
  logic [31:0] exp_m_addr, exp_m_wdata, exp_i_rdata, exp_d_rdata;
  logic [3:0]  exp_m_be;

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      ph <= 0; busy_cyc <= 0; dstreak <= 0; own_d <= 1'b0;
      exp_m_req <= 1'b0; exp_m_we <= 1'b0; exp_m_addr <= '0; exp_m_wdata <= '0;
      exp_m_be <= '0; exp_i_rdata <= '0; exp_d_rdata <= '0;
      exp_iack <= 1'b0; exp_dack <= 1'b0; exp_err <= 1'b0; exp_grant <= 1'b0;
    end else begin
      exp_iack <= 1'b0;
      exp_dack <= 1'b0;
      exp_err  <= 1'b0;
      if (ph == 2) begin
        ph <= 0;
      end else if (ph == 1) begin
        busy_cyc <= busy_cyc + 1;
        if (m_ack === 1'b1 || busy_cyc + 1 == int'(TO)) begin
          ph        <= 2;
          exp_m_req <= 1'b0;
          exp_grant <= 1'b0;
          exp_err   <= (m_ack !== 1'b1);
          if (own_d) begin
            exp_dack    <= 1'b1;
            exp_d_rdata <= (m_ack === 1'b1) ? m_rdata : 32'h0;
          end else begin
            exp_iack    <= 1'b1;
            exp_i_rdata <= (m_ack === 1'b1) ? m_rdata : 32'h0;
          end
        end
      end else if (d_req && (!i_req || dstreak < int'(SL))) begin
        ph <= 1; busy_cyc <= 0; own_d <= 1'b1;
        dstreak <= i_req ? dstreak + 1 : 0;
        exp_m_req <= 1'b1; exp_grant <= 1'b1; exp_m_we <= d_we;
        exp_m_addr <= d_addr; exp_m_wdata <= d_wdata; exp_m_be <= d_be;
      end else if (i_req) begin
        ph <= 1; busy_cyc <= 0; own_d <= 1'b0; dstreak <= 0;
        exp_m_req <= 1'b1; exp_grant <= 1'b0; exp_m_we <= 1'b0;
        exp_m_addr <= i_addr; exp_m_be <= 4'hF;
      end
    end
  end

  // Per-cycle comparison against the model.
  initial forever begin
    @(negedge clk);
    if (chk_en) begin
      chk("m_req",    32'(m_req),        32'(exp_m_req));
      chk("m_we",     32'(m_we),         32'(exp_m_we));
      chk("m_addr",   m_addr,            exp_m_addr);
      chk("m_wdata",  m_wdata,           exp_m_wdata);
      chk("m_be",     32'(m_be),         32'(exp_m_be));
      chk("i_rdata",  i_rdata,           exp_i_rdata);
      chk("d_rdata",  d_rdata,           exp_d_rdata);
      chk("inst_ack", 32'(inst_mem_ack), 32'(exp_iack));
      chk("data_ack", 32'(data_mem_ack), 32'(exp_dack));
      chk("bus_err",  32'(bus_err),      32'(exp_err));
      chk("grant_d",  32'(grant_d),      32'(exp_grant));
    end
  end

  // Memory responder: acks after wait_st cycles of m_req; spurious pulses on request.
  bit          resp_en  = 1'b1;
  int          wait_st  = 0;
  logic [31:0] rd_val   = '0;
  bit          spur_req = 1'b0;
  initial begin
    int  wcnt;
    bit  spur_seen;
    wcnt = 0;
    spur_seen = 1'b0;
    forever begin
      @(negedge clk); #1;
      m_ack = 1'b0;
      if (spur_req != spur_seen) begin
        spur_seen = spur_req;
        m_ack   = 1'b1;
        m_rdata = 32'hDEADBEEF;
      end else if (m_req === 1'b1 && resp_en) begin
        if (wcnt == wait_st) begin
          m_ack   = 1'b1;
          m_rdata = rd_val;
          wcnt    = 0;
        end else begin
          wcnt++;
        end
      end else begin
        wcnt = 0;
      end
    end
  end

  // Grant logger: records the owner of every new memory request.
  logic glog [64];
  int   gcount = 0;
  initial begin
    logic prev;
    prev = 1'b0;
    forever begin
      @(negedge clk);
      if (m_req === 1'b1 && prev !== 1'b1 && gcount < 64) begin
        glog[gcount] = grant_d;
        gcount++;
      end
      prev = m_req;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic wait_ack(input bit want_d, output int lat);
    lat = -1;
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if ((want_d ? data_mem_ack : inst_mem_ack) === 1'b1) begin
        lat = n;
        break;
      end
    end
    chk(want_d ? "d_ack_seen" : "i_ack_seen", 32'(lat > 0), 32'd1);
  endtask

  int lat, busy, acks, g0;
  bit exp_ord [10] = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};

  initial begin
    reset = 1'b0;
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0;
    i_addr = '0; d_addr = '0; d_wdata = '0; d_be = '0;

    // Reset state
    repeat (2) @(negedge clk);
    chk("rst_m_req", 32'(m_req), 32'd0);
    chk("rst_m_addr", m_addr, 32'd0);
    chk("rst_m_be", 32'(m_be), 32'd0);
    chk("rst_i_rdata", i_rdata, 32'd0);
    chk("rst_d_rdata", d_rdata, 32'd0);
    chk("rst_acks", 32'({inst_mem_ack, data_mem_ack, bus_err, grant_d}), 32'd0);
    #1 reset = 1'b1;
    chk_en = 1'b1;

    // Single fetch, zero-wait memory
    @(negedge clk); #1;
    rd_val = 32'h8C080004; wait_st = 0;
    i_addr = 32'h00400000; i_req = 1'b1;
    @(negedge clk);
    chk("fetch_m_req", 32'(m_req), 32'd1);
    chk("fetch_m_addr", m_addr, 32'h00400000);
    chk("fetch_m_be", 32'(m_be), 32'hF);
    chk("fetch_m_we", 32'(m_we), 32'd0);
    wait_ack(1'b0, lat);
    chk("fetch_latency", 32'(lat + 1), 32'd2);
    chk("fetch_i_rdata", i_rdata, 32'h8C080004);
    #1 i_req = 1'b0;

    // Store with 3 wait states
    @(negedge clk); #1;
    rd_val = 32'h5555AAAA; wait_st = 3;
    d_we = 1'b1; d_addr = 32'h10010008; d_be = 4'b0011; d_wdata = 32'hABCD1234; d_req = 1'b1;
    busy = 0; acks = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m_req === 1'b1) begin
        busy++;
        chk("store_m_we", 32'(m_we), 32'd1);
        chk("store_m_addr", m_addr, 32'h10010008);
        chk("store_m_wdata", m_wdata, 32'hABCD1234);
        chk("store_m_be", 32'(m_be), 32'h3);
        chk("store_grant_busy", 32'(grant_d), 32'd1);
      end else begin
        chk("store_grant_idle", 32'(grant_d), 32'd0);
      end
      if (data_mem_ack === 1'b1) begin
        acks++;
        break;
      end
    end
    chk("store_busy_cycles", 32'(busy), 32'd4);
    chk("store_d_rdata", d_rdata, 32'h5555AAAA);
    #1 d_req = 1'b0; d_we = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (data_mem_ack === 1'b1) acks++;
    end
    chk("store_ack_once", 32'(acks), 32'd1);

    // Contention with zero-wait memory
    @(negedge clk); #1;
    wait_st = 0; rd_val = 32'h11112222;
    i_addr = 32'h00400010; d_addr = 32'h10010000; d_we = 1'b0; d_be = 4'hF;
    g0 = gcount;
    i_req = 1'b1; d_req = 1'b1;
    for (int n = 0; n < 100 && gcount < g0 + 10; n++) @(negedge clk);
    chk("contention_grants", 32'(gcount >= g0 + 10), 32'd1);
    for (int n = 0; n < 10 && !(inst_mem_ack === 1'b1 || data_mem_ack === 1'b1); n++)
      @(negedge clk);
    #1 i_req = 1'b0; d_req = 1'b0;
    for (int k = 0; k < 10; k++)
      if (g0 + k < 64)
        chk($sformatf("grant_order%0d", k), 32'(glog[g0 + k]), 32'(exp_ord[k]));

    // Timeout: load with no memory response
    @(negedge clk); #1;
    resp_en = 1'b0;
    d_addr = 32'h10010020; d_we = 1'b0; d_req = 1'b1;
    busy = 0;
    for (int n = 0; n < 40; n++) begin
      @(negedge clk);
      if (m_req === 1'b1) busy++;
      if (data_mem_ack === 1'b1) break;
    end
    chk("tmo_busy_cycles", 32'(busy), 32'd8);
    chk("tmo_ack", 32'(data_mem_ack), 32'd1);
    chk("tmo_bus_err", 32'(bus_err), 32'd1);
    chk("tmo_d_rdata", d_rdata, 32'd0);
    #1 d_req = 1'b0;

    // Reset while fetch is in flight
    @(negedge clk); #1;
    i_addr = 32'h00400040; i_req = 1'b1;
    @(negedge clk);
    chk("rstmid_busy", 32'(m_req), 32'd1);
    #2 reset = 1'b0;
    #1 chk("rstmid_m_req_async", 32'(m_req), 32'd0);
    i_req = 1'b0;
    repeat (2) begin
      @(negedge clk);
      chk("rstmid_no_ack", 32'({inst_mem_ack, data_mem_ack}), 32'd0);
    end
    #1 reset = 1'b1;
    resp_en = 1'b1; wait_st = 0; rd_val = 32'h0BADF00D;
    d_addr = 32'h10010030; d_we = 1'b0; d_req = 1'b1;
    wait_ack(1'b1, lat);
    chk("rstmid_d_latency", 32'(lat), 32'd2);
    chk("rstmid_d_rdata", d_rdata, 32'h0BADF00D);
    #1 d_req = 1'b0;

    // Spurious m_ack while idle
    @(negedge clk); #1;
    spur_req = ~spur_req;
    repeat (4) begin
      @(negedge clk);
      chk("spur_no_ack", 32'({inst_mem_ack, data_mem_ack, bus_err}), 32'd0);
      chk("spur_no_req", 32'(m_req), 32'd0);
    end
    #1 rd_val = 32'h24020001; i_addr = 32'h00400080; i_req = 1'b1;
    wait_ack(1'b0, lat);
    chk("spur_fetch_latency", 32'(lat), 32'd2);
    chk("spur_fetch_rdata", i_rdata, 32'h24020001);
    #1 i_req = 1'b0;
    repeat (3) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
